// File: rtl/vpu_dst_port.sv
// Result-packing write-back stage: gathers EXEC_CNT lane chunks into one SRAM line
// and writes LEN lines to consecutive addresses over a req/ack port.
module vpu_dst_port #(
    parameter int unsigned DWIDTH_PER_EXEC = 256,
    parameter int unsigned EXEC_CNT        = 2,
    parameter int unsigned ADDR_W          = 12,
    parameter int unsigned LEN_W           = 8,
    localparam int unsigned SRAM_DATA_WIDTH = DWIDTH_PER_EXEC * EXEC_CNT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [LEN_W-1:0]           len_i,
    output logic                       done_o,
    input  logic                       result_valid_i,
    input  logic [DWIDTH_PER_EXEC-1:0] result_data_i,
    output logic                       result_ready_o,
    output logic                       wreq_o,
    input  logic                       wack_i,
    output logic [ADDR_W-1:0]          waddr_o,
    output logic [SRAM_DATA_WIDTH-1:0] wdata_o,
    output logic                       wlast_o
);

    localparam int unsigned CNT_W = $clog2(EXEC_CNT);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StWrite   = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [LEN_W-1:0]           remain_q, remain_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SRAM_DATA_WIDTH-1:0] line_q, line_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d   = waddr_i;
                    remain_d = len_i;
                    state_d  = (len_i != '0) ? StCollect : StDone;
                end
            end
            StCollect: begin
                if (result_valid_i) begin
                    // Chunk 0 lands in the LSBs, later chunks climb upward.
                    for (int unsigned k = 0; k < EXEC_CNT; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[k*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = result_data_i;
                        end
                    end
                    if (cnt_q == CNT_W'(EXEC_CNT - 1)) begin
                        cnt_d   = '0;
                        state_d = StWrite;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StWrite: begin
                if (wack_i) begin
                    remain_d = remain_q - LEN_W'(1);
                    addr_d   = addr_q + ADDR_W'(1);
                    state_d  = (remain_q == LEN_W'(1)) ? StDone : StCollect;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
        end
    end

    assign done_o         = (state_q == StDone);
    assign result_ready_o = (state_q == StCollect);
    assign wreq_o         = (state_q == StWrite);
    assign wlast_o        = (state_q == StWrite) && (remain_q == LEN_W'(1));
    assign waddr_o        = addr_q;
    assign wdata_o        = line_q;

endmodule
